rs485_rx_deframer: RTL and testbench
====================================

# rs485_rx_deframer

Receive-side stage of the RS485 controller: oversamples the `Rx` line, recovers 8N1 bytes, and assembles addressed three-byte frames (address, data-high, data-low) into 16-bit words. It sits directly upstream of the receive word FIFO and mirrors the transmit path, which drains the TX FIFO onto `Tx`. Frames whose address byte does not match `sa` are discarded. Matched frames produce one word through a valid/ready handshake.

## Interface
- `CLKS_PER_BIT`, default 16: PCLK cycles per bit; must be even and ≥4.
- `GAP_BITS`, default 20: maximum idle bit-times between bytes of one frame.
- `PCLK`, input, 1: single clock, rising edge.
- `rst_tx`, input, 1: reset; asynchronous assert, active-low.
- `Rx`, input, 1: RS485 receive line; idles high.
- `en`, input, 1: receive enable. When low, the block finishes the current byte, then holds the byte FSM in IDLE.
- `sa`, input, 8: own slave address, sampled when the address byte completes.
- `word_out`, output, 16: assembled word, {hi, lo}.
- `word_valid`, output, 1: `word_out` holds an unconsumed word.
- `word_ready`, input, 1: the downstream FIFO accepts the word.
- `seq_detect`, output, 1: one-cycle pulse when the address byte matches `sa`.
- `frame_err`, output, 1: one-cycle pulse on a bad start or stop bit, or on a gap timeout mid-frame.
- `overrun`, output, 1: one-cycle pulse when a word completes while `word_valid` is already high.
- `busy`, output, 1: high whenever the frame FSM is not in WAIT_ADDR or the byte FSM is not in IDLE.

## Operation
- `Rx` passes through a 2-flop synchronizer. Both flops reset to 1.
- Byte FSM states: IDLE → START → DATA → STOP → IDLE.
  - IDLE: a synced falling edge with `en` high moves to START and clears the bit counter.
  - START: resample at `CLKS_PER_BIT/2`. A 0 moves to DATA. A 1 is a glitch: return to IDLE with no error.
  - DATA: sample every `CLKS_PER_BIT` at mid-bit, 8 bits, LSB first, shifted into the byte register.
  - STOP: sample at mid-bit. A 1 yields `byte_done`. A 0 pulses `frame_err` and causes no `byte_done`. Either way, return to IDLE at the sample point.
- Frame FSM states: WAIT_ADDR → GET_HI → GET_LO → WAIT_ADDR.
  - WAIT_ADDR: on `byte_done`, if byte == `sa`, pulse `seq_detect` and go to GET_HI. Otherwise stay.
  - GET_HI: on `byte_done`, latch the hi byte and go to GET_LO.
  - GET_LO: on `byte_done`, form {hi, lo} and go to WAIT_ADDR.
    - If `word_valid` is low: load `word_out` and set `word_valid`.
    - If `word_valid` is high: drop the new word, pulse `overrun`, leave `word_out` unchanged.
- Gap timer:
  - Counts PCLK cycles while the frame FSM is in GET_HI or GET_LO and the byte FSM is in IDLE. It clears on any start.
  - Reaching `GAP_BITS*CLKS_PER_BIT` pulses `frame_err` and returns the frame FSM to WAIT_ADDR.
  - Width is `$clog2(GAP_BITS*CLKS_PER_BIT+1)`.
- A stop-bit error in GET_HI or GET_LO also returns the frame FSM to WAIT_ADDR.
- Handshake: `word_valid` clears on the cycle `word_valid && word_ready` is sampled.
  - If a new word completes in that same cycle, it is loaded and `word_valid` stays high, with no overrun.
- `word_out` is stable while `word_valid` is high.

## Timing
- Reset values: `word_out` = 0; `word_valid`, `seq_detect`, `frame_err`, `overrun` and `busy` = 0. Both FSMs go to IDLE/WAIT_ADDR and all counters clear.
- Reset asserted mid-frame aborts immediately. No partial word is emitted after release.
- Synchronizer latency is 2 cycles from an `Rx` edge to the internal edge.
- Stop-bit sample point: `9.5*CLKS_PER_BIT` cycles after the synced start edge.
- `seq_detect` and `word_valid` rise on the PCLK edge after the stop-bit sample of the corresponding byte.
- `frame_err` and `overrun` pulse for exactly one cycle at the same point.
- Back-to-back bytes (stop bit followed immediately by start) are accepted. The byte FSM is in IDLE by mid-stop-bit, so it catches the next falling edge.

## Structure
- Shared package `rs485_pkg`:
  - byte FSM enum `{IDLE, START, DATA, STOP}`;
  - frame FSM enum `{WAIT_ADDR, GET_HI, GET_LO}`;
  - `RS485_DATA_BITS` = 8.
- One sub-module, `rs485_uart_rx`: synchronizer plus byte FSM, outputting `byte_done`, `byte`, `stop_err` and `idle`.
- The top level holds the frame FSM, gap timer and output register.

## Test plan
All scenarios use `CLKS_PER_BIT=4` and `GAP_BITS=20`.
- **Addressed frame:** `sa`=0x5A, send 0x5A, 0x12, 0x34 with `word_ready`=1 → one `seq_detect` pulse, then `word_out`=0x1234 and `word_valid` high for 1 cycle.
- **Address mismatch:** `sa`=0x5A, send 0x33, 0x12, 0x34 → no `seq_detect`, `word_valid` stays 0. A following frame 0x5A, 0xAB, 0xCD yields 0xABCD.
- **Bad stop bit:** send 0x5A, then 0x12 with stop bit = 0 → `frame_err` pulse, FSM back in WAIT_ADDR. Sending 0x34 then produces no word.
- **Gap timeout:** send 0x5A, 0x12, then idle 80 cycles → `frame_err` at cycle 80, `busy` falls. A later 0x34 is ignored.
- **Overrun and simultaneous accept:**
  - `word_ready`=0; two frames yielding 0x1111 then 0x2222 → `overrun` pulse, `word_out` stays 0x1111.
  - Repeat with `word_ready` rising in the completion cycle → `word_out`=0x2222 and no `overrun`.
- **Reset mid-frame:** assert `rst_tx` during the DATA bits of the hi byte → all outputs 0. After release, a clean frame 0x5A, 0xBE, 0xEF yields 0xBEEF.

Source files
------------

// File: rtl/rs485_pkg.sv
// Shared types and constants for the RS485 receive path.
package rs485_pkg;

  localparam int RS485_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } byte_state_t;

  typedef enum logic [1:0] {
    WAIT_ADDR,
    GET_HI,
    GET_LO
  } frame_state_t;

endpackage

// File: rtl/rs485_uart_rx.sv
// Rx synchronizer plus 8N1 byte FSM; byte_done/stop_err are asserted in the
// stop-bit sample cycle so the frame logic can register them at that edge.
module rs485_uart_rx
  import rs485_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       PCLK,
  input  logic       rst_tx,
  input  logic       Rx,
  input  logic       en,
  output logic       byte_done,
  output logic [7:0] data_byte,
  output logic       stop_err,
  output logic       idle,
  output logic [1:0] byte_state
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       BIT_LAST = 3'(RS485_DATA_BITS - 1);

  byte_state_t      state;
  logic             sync1;
  logic             sync2;
  logic             sync_prev;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             fall;
  logic             stop_sample;

  assign fall        = sync_prev & ~sync2;
  assign stop_sample = (state == STOP) && (cnt == CNT_LAST);
  assign byte_done   = stop_sample & sync2;
  assign stop_err    = stop_sample & ~sync2;
  assign data_byte   = shreg;
  assign idle        = (state == IDLE);
  assign byte_state  = state;

  always_ff @(posedge PCLK or negedge rst_tx) begin
    if (!rst_tx) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync_prev <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
    end else begin
      sync1     <= Rx;
      sync2     <= sync1;
      sync_prev <= sync2;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (fall && en) begin
            // One cycle has already elapsed since the synced edge.
            cnt     <= CNT_W'(1);
            bit_idx <= '0;
            state   <= START;
          end
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt   <= '0;
            state <= sync2 ? IDLE : DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            shreg <= {sync2, shreg[7:1]};
            if (bit_idx == BIT_LAST) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rs485_rx_deframer.sv
// Assembles addressed {addr, hi, lo} byte frames into 16-bit words.
// Handshake: word_out is held stable while word_valid is high; a word is
// consumed on any rising PCLK edge where word_valid && word_ready.
module rs485_rx_deframer
  import rs485_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int GAP_BITS     = 20
) (
  input  logic        PCLK,
  input  logic        rst_tx,
  input  logic        Rx,
  input  logic        en,
  input  logic [7:0]  sa,
  output logic [15:0] word_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        seq_detect,
  output logic        frame_err,
  output logic        overrun,
  output logic        busy,
  output logic [1:0]  frame_state,
  output logic [1:0]  byte_state
);

  localparam int GAP_LIMIT = GAP_BITS * CLKS_PER_BIT;
  localparam int GAP_W     = $clog2(GAP_LIMIT + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LIMIT - 1);

  frame_state_t state;
  logic [7:0]   hi_byte;
  logic [GAP_W-1:0] gap_cnt;
  logic         byte_done;
  logic [7:0]   data_byte;
  logic         stop_err;
  logic         idle;
  logic         gap_run;
  logic         gap_hit;

  rs485_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_rx (
    .PCLK      (PCLK),
    .rst_tx    (rst_tx),
    .Rx        (Rx),
    .en        (en),
    .byte_done (byte_done),
    .data_byte (data_byte),
    .stop_err  (stop_err),
    .idle      (idle),
    .byte_state(byte_state)
  );

  assign gap_run     = ((state == GET_HI) || (state == GET_LO)) && idle;
  assign gap_hit     = gap_run && (gap_cnt == GAP_LAST);
  assign busy        = (state != WAIT_ADDR) || !idle;
  assign frame_state = state;

  always_ff @(posedge PCLK or negedge rst_tx) begin
    if (!rst_tx) begin
      state      <= WAIT_ADDR;
      hi_byte    <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      seq_detect <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      gap_cnt    <= '0;
    end else begin
      seq_detect <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= stop_err || gap_hit;
      gap_cnt    <= (gap_run && !gap_hit) ? gap_cnt + GAP_W'(1) : '0;
      if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
      case (state)
        WAIT_ADDR: begin
          if (byte_done && (data_byte == sa)) begin
            seq_detect <= 1'b1;
            state      <= GET_HI;
          end
        end
        GET_HI: begin
          if (byte_done) begin
            hi_byte <= data_byte;
            state   <= GET_LO;
          end else if (stop_err || gap_hit) begin
            state <= WAIT_ADDR;
          end
        end
        GET_LO: begin
          if (byte_done) begin
            // A word accepted this same cycle frees the register for the new one.
            if (!word_valid || word_ready) begin
              word_out   <= {hi_byte, data_byte};
              word_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
            state <= WAIT_ADDR;
          end else if (stop_err || gap_hit) begin
            state <= WAIT_ADDR;
          end
        end
        default: state <= WAIT_ADDR;
      endcase
    end
  end

endmodule

// File: tb/tb_rs485_rx_deframer.sv
// Self-checking bench for rs485_rx_deframer with CLKS_PER_BIT=4, GAP_BITS=20.
module tb_rs485_rx_deframer;
  import rs485_pkg::*;

  localparam int CPB = 4;
  localparam int GAP = 20;

  logic        PCLK;
  logic        rst_tx;
  logic        Rx;
  logic        en;
  logic [7:0]  sa;
  logic [15:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic        seq_detect;
  logic        frame_err;
  logic        overrun;
  logic        busy;
  logic [1:0]  frame_state;
  logic [1:0]  byte_state;

  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int acc_cnt  = 0;
  int seq_cnt  = 0;
  int err_cnt  = 0;
  int ovr_cnt  = 0;

  rs485_rx_deframer #(
    .CLKS_PER_BIT(CPB),
    .GAP_BITS    (GAP)
  ) dut (
    .PCLK       (PCLK),
    .rst_tx     (rst_tx),
    .Rx         (Rx),
    .en         (en),
    .sa         (sa),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .seq_detect (seq_detect),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy),
    .frame_state(frame_state),
    .byte_state (byte_state)
  );

  // Clock and watchdog.
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted word is compared with the oldest expectation.
  always @(negedge PCLK) begin
    if (rst_tx) begin
      if (seq_detect) seq_cnt++;
      if (frame_err)  err_cnt++;
      if (overrun)    ovr_cnt++;
      if (word_valid && word_ready) begin
        acc_cnt++;
        check("word", 32'(word_out), (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hDEAD_0000);
      end
    end
  end

  // Drivers: all tasks start and end 1 time unit after a rising edge.
  task automatic idle_cycles(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      Rx = bits[i];
      repeat (CPB) @(posedge PCLK);
      #1;
    end
    Rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] hi, input logic [7:0] lo);
    send_byte(a);
    send_byte(hi);
    send_byte(lo);
    idle_cycles(8);
  endtask

  task automatic wait_acc(input string tag, input int base, input int n);
    for (int i = 0; i < 60; i++) begin
      if (acc_cnt >= base + n) break;
      idle_cycles(1);
    end
    check(tag, 32'(acc_cnt - base), 32'(n));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_word_out"}, 32'(word_out), 32'h0);
    check({tag, "_word_valid"}, 32'(word_valid), 32'h0);
    check({tag, "_seq_detect"}, 32'(seq_detect), 32'h0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'h0);
    check({tag, "_overrun"}, 32'(overrun), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    int base;
    int seq0;
    int err0;
    int ovr0;

    rst_tx     = 1'b0;
    Rx         = 1'b1;
    en         = 1'b1;
    sa         = 8'h5A;
    word_ready = 1'b1;
    idle_cycles(3);
    check_reset_outputs("reset");
    rst_tx = 1'b1;
    idle_cycles(6);

    // Addressed frame.
    base = acc_cnt;
    seq0 = seq_cnt;
    exp_q.push_back(16'h1234);
    send_frame(8'h5A, 8'h12, 8'h34);
    wait_acc("addr_frame_acc", base, 1);
    check("addr_frame_seq", 32'(seq_cnt - seq0), 32'd1);
    check("addr_frame_valid_one_cycle", 32'(word_valid), 32'h0);

    // Address mismatch, then a matching frame.
    base = acc_cnt;
    seq0 = seq_cnt;
    send_frame(8'h33, 8'h12, 8'h34);
    idle_cycles(10);
    check("mismatch_seq", 32'(seq_cnt - seq0), 32'd0);
    check("mismatch_acc", 32'(acc_cnt - base), 32'd0);
    exp_q.push_back(16'hABCD);
    send_frame(8'h5A, 8'hAB, 8'hCD);
    wait_acc("mismatch_follow_acc", base, 1);

    // Bad stop bit on the hi byte.
    base = acc_cnt;
    err0 = err_cnt;
    send_byte(8'h5A);
    send_byte(8'h12, 1'b0);
    idle_cycles(4);
    check("badstop_err", 32'(err_cnt - err0), 32'd1);
    check("badstop_state", 32'(frame_state), 32'(WAIT_ADDR));
    check("badstop_busy", 32'(busy), 32'h0);
    send_byte(8'h34);
    idle_cycles(20);
    check("badstop_no_word", 32'(acc_cnt - base), 32'd0);

    // Gap timeout after the hi byte.
    base = acc_cnt;
    err0 = err_cnt;
    send_byte(8'h5A);
    send_byte(8'h12);
    idle_cycles(GAP * CPB - 1);
    check("gap_err_early", 32'(frame_err), 32'h0);
    check("gap_busy_before", 32'(busy), 32'h1);
    idle_cycles(1);
    check("gap_err_pulse", 32'(frame_err), 32'h1);
    check("gap_busy_after", 32'(busy), 32'h0);
    send_byte(8'h34);
    idle_cycles(20);
    check("gap_no_word", 32'(acc_cnt - base), 32'd0);
    check("gap_err_count", 32'(err_cnt - err0), 32'd1);

    // Overrun with word_ready held low.
    word_ready = 1'b0;
    base = acc_cnt;
    ovr0 = ovr_cnt;
    exp_q.push_back(16'h1111);
    send_frame(8'h5A, 8'h11, 8'h11);
    send_frame(8'h5A, 8'h22, 8'h22);
    check("overrun_pulse", 32'(ovr_cnt - ovr0), 32'd1);
    check("overrun_word_held", 32'(word_out), 32'h1111);
    check("overrun_valid", 32'(word_valid), 32'h1);
    word_ready = 1'b1;
    wait_acc("overrun_drain", base, 1);
    word_ready = 1'b0;

    // Ready rises in the completion cycle: accept old and load new together.
    base = acc_cnt;
    ovr0 = ovr_cnt;
    exp_q.push_back(16'h3333);
    send_frame(8'h5A, 8'h33, 8'h33);
    exp_q.push_back(16'h4444);
    send_byte(8'h5A);
    send_byte(8'h44);
    fork
      send_byte(8'h44);
      begin
        repeat (10 * CPB - 1) @(posedge PCLK);
        #1;
        word_ready = 1'b1;
      end
    join
    wait_acc("simul_acc", base, 2);
    check("simul_no_overrun", 32'(ovr_cnt - ovr0), 32'd0);
    check("simul_last_word", 32'(word_out), 32'h4444);

    // Reset during the data bits of the hi byte.
    base = acc_cnt;
    send_byte(8'h5A);
    Rx = 1'b0;
    idle_cycles(10);
    rst_tx = 1'b0;
    #1;
    check_reset_outputs("midreset");
    idle_cycles(3);
    Rx = 1'b1;
    rst_tx = 1'b1;
    idle_cycles(40);
    check("midreset_no_word", 32'(acc_cnt - base), 32'd0);
    exp_q.push_back(16'hBEEF);
    send_frame(8'h5A, 8'hBE, 8'hEF);
    wait_acc("midreset_follow_acc", base, 1);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
